// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder state encoding, padding constants,
// and the initial hash value and round constants used by the engine.
package sha256_pkg;

  localparam int unsigned SHA256_WORD_W        = 32;
  localparam int unsigned SHA256_LEN_W         = 64;
  localparam int unsigned SHA256_IDX_W         = 4;
  localparam int unsigned SHA256_WORDS_PER_BLK = 16;
  localparam int unsigned SHA256_LEN_IDX       = 14;

  localparam logic [SHA256_WORD_W-1:0] SHA256_PAD_MARKER = 32'h8000_0000;

  typedef enum logic [2:0] {
    PAD_IDLE,
    PAD_DATA,
    PAD_PAD,
    PAD_ZERO,
    PAD_LEN_HI,
    PAD_LEN_LO
  } pad_state_e;

  // Initial hash value H(0), H0 in the top word
  localparam logic [255:0] SHA256_H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Round constants K[0..63]
  localparam logic [SHA256_WORD_W-1:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_padder_if.sv
// Message-in / FIFO-write bundle of the SHA-256 padder.
//   slave  : padder view (consumes message words, writes the FIFO)
//   master : producer + FIFO view (drives message words, reports full)
interface sha256_padder_if;
  import sha256_pkg::*;

  logic                     msg_start_i;
  logic                     msg_vld_i;
  logic                     msg_rdy_o;
  logic [SHA256_WORD_W-1:0] msg_dat_i;
  logic                     msg_last_i;
  logic [2:0]               msg_bytes_i;
  logic                     fifo_wr_en_o;
  logic [SHA256_WORD_W-1:0] fifo_wr_dat_o;
  logic                     fifo_full_i;
  logic                     busy_o;
  logic                     done_o;

  modport slave (
    input  msg_start_i, msg_vld_i, msg_dat_i, msg_last_i, msg_bytes_i, fifo_full_i,
    output msg_rdy_o, fifo_wr_en_o, fifo_wr_dat_o, busy_o, done_o
  );

  modport master (
    output msg_start_i, msg_vld_i, msg_dat_i, msg_last_i, msg_bytes_i, fifo_full_i,
    input  msg_rdy_o, fifo_wr_en_o, fifo_wr_dat_o, busy_o, done_o
  );

endinterface

// File: rtl/sha256_out_stage.sv
// One-entry registered FIFO write stage.
//   clk, rst     : clock, async active-high reset
//   load/load_dat: new word for the stage (only when loadable_c)
//   fifo_full    : downstream FIFO full
//   out_dat      : held word, drives the FIFO write data
//   loadable_c   : stage empty or draining this cycle
//   wr_en_c      : FIFO write strobe
module sha256_out_stage
  import sha256_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [SHA256_WORD_W-1:0] load_dat,
  input  logic                     fifo_full,
  output logic [SHA256_WORD_W-1:0] out_dat,
  output logic                     loadable_c,
  output logic                     wr_en_c
);

  logic out_vld;

  assign wr_en_c    = out_vld & ~fifo_full;
  assign loadable_c = ~out_vld | ~fifo_full;

  // Load wins over drain so back-to-back words flow without a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (load) begin
      out_vld <= 1'b1;
      out_dat <= load_dat;
    end else if (wr_en_c) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: turns a byte-counted word stream into whole
// padded 512-bit blocks (16 words each) written into the engine FIFO.
//   clk, rst : clock, async active-high reset
//   bus      : message input handshake, FIFO write port, busy/done status
module sha256_padder
  import sha256_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  sha256_padder_if.slave bus
);

  pad_state_e               state_q, state_d;
  logic [SHA256_LEN_W-1:0]  bitcnt_q, add_bits;
  logic [SHA256_IDX_W-1:0]  widx_q, widx_inc;
  logic                     clr, load, done_q, done_d, loadable_c, to_len;
  logic [SHA256_WORD_W-1:0] load_dat, keep_mask, marker;
  logic [2:0]               nb;

  // Byte counts above 4 behave as a full word
  assign nb        = (bus.msg_bytes_i > 3'd4) ? 3'd4 : bus.msg_bytes_i;
  assign keep_mask = ~(32'hFFFF_FFFF >> {nb[1:0], 3'b000});
  assign marker    = SHA256_PAD_MARKER >> {nb[1:0], 3'b000};

  // The word being written now lands at widx_q; skip ZERO when the next slot is the length
  assign widx_inc = widx_q + SHA256_IDX_W'(1);
  assign to_len   = (widx_inc == SHA256_IDX_W'(SHA256_LEN_IDX));

  assign bus.msg_rdy_o = (state_q == PAD_DATA) & loadable_c;
  assign bus.busy_o    = (state_q != PAD_IDLE);
  assign bus.done_o    = done_q;

  // State, counters and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PAD_IDLE;
      bitcnt_q <= '0;
      widx_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (clr) begin
        bitcnt_q <= '0;
        widx_q   <= '0;
      end else begin
        bitcnt_q <= bitcnt_q + add_bits;
        if (load) widx_q <= widx_inc;
      end
    end
  end

  // Next state and word selection
  always_comb begin
    state_d  = state_q;
    clr      = 1'b0;
    load     = 1'b0;
    load_dat = '0;
    add_bits = '0;
    done_d   = 1'b0;
    unique case (state_q)
      PAD_IDLE: begin
        // A start overlapping the done pulse belongs to the finished message
        if (bus.msg_start_i && !done_q) begin
          clr     = 1'b1;
          state_d = PAD_DATA;
        end
      end
      PAD_DATA: begin
        if (bus.msg_vld_i && loadable_c) begin
          load = 1'b1;
          if (!bus.msg_last_i) begin
            load_dat = bus.msg_dat_i;
            add_bits = SHA256_LEN_W'(32);
          end else if (nb == 3'd4) begin
            load_dat = bus.msg_dat_i;
            add_bits = SHA256_LEN_W'(32);
            state_d  = PAD_PAD;
          end else begin
            load_dat = (bus.msg_dat_i & keep_mask) | marker;
            add_bits = SHA256_LEN_W'({nb, 3'b000});
            state_d  = to_len ? PAD_LEN_HI : PAD_ZERO;
          end
        end
      end
      PAD_PAD: begin
        if (loadable_c) begin
          load     = 1'b1;
          load_dat = SHA256_PAD_MARKER;
          state_d  = to_len ? PAD_LEN_HI : PAD_ZERO;
        end
      end
      PAD_ZERO: begin
        if (loadable_c) begin
          load    = 1'b1;
          state_d = to_len ? PAD_LEN_HI : PAD_ZERO;
        end
      end
      PAD_LEN_HI: begin
        if (loadable_c) begin
          load     = 1'b1;
          load_dat = bitcnt_q[63:32];
          state_d  = PAD_LEN_LO;
        end
      end
      PAD_LEN_LO: begin
        if (loadable_c) begin
          load     = 1'b1;
          load_dat = bitcnt_q[31:0];
          done_d   = 1'b1;
          state_d  = PAD_IDLE;
        end
      end
      default: state_d = PAD_IDLE;
    endcase
  end

  sha256_out_stage u_out_stage (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_dat   (load_dat),
    .fifo_full  (bus.fifo_full_i),
    .out_dat    (bus.fifo_wr_dat_o),
    .loadable_c (loadable_c),
    .wr_en_c    (bus.fifo_wr_en_o)
  );

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: expected FIFO words are queued when a
// message is issued; a negedge monitor pops and compares every FIFO write.
module tb_sha256_padder;

  typedef struct {
    logic [31:0] dat;
    bit          last;
  } exp_t;

  logic clk;
  logic rst;
  sha256_padder_if pif ();

  sha256_padder dut (
    .clk (clk),
    .rst (rst),
    .bus (pif)
  );

  exp_t       sb[$];
  int         errors;
  int         checks;
  int         word_no;
  int         done_cnt;
  int         exp_done;
  bit         stall_en;
  logic [7:0] msg_buf [0:63];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Random FIFO-full generator, changes just after each rising edge
  initial begin
    pif.fifo_full_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pif.fifo_full_i = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: done pulse placement, no write while full, word scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (pif.done_o) begin
        checks++;
        done_cnt++;
        if (!(sb.size() == 1 && sb[0].last)) begin
          errors++;
          $display("FAIL done_pos: done_o with %0d words still expected (need 1, the length word)", sb.size());
        end
      end
      if (pif.fifo_full_i) begin
        checks++;
        if (pif.fifo_wr_en_o) begin
          errors++;
          $display("FAIL wr_while_full: fifo_wr_en_o=1 required 0");
        end
      end
      if (pif.fifo_wr_en_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got %08h with nothing expected", pif.fifo_wr_dat_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (pif.fifo_wr_dat_o !== e.dat) begin
            errors++;
            $display("FAIL word[%0d]: got %08h required %08h", word_no, pif.fifo_wr_dat_o, e.dat);
          end
          word_no = e.last ? 0 : word_no + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic push_word(input logic [31:0] d, input bit last);
    exp_t e;
    e.dat  = d;
    e.last = last;
    sb.push_back(e);
  endtask

  // Byte-level FIPS 180-4 padding of msg_buf[0..nbytes-1]
  task automatic push_model(input int nbytes);
    int          total;
    logic [63:0] bl;
    logic [7:0]  b;
    logic [31:0] w;
    total = ((nbytes + 9 + 63) / 64) * 64;
    bl    = 64'(nbytes) * 64'd8;
    w     = '0;
    for (int i = 0; i < total; i++) begin
      if (i < nbytes)           b = msg_buf[i];
      else if (i == nbytes)     b = 8'h80;
      else if (i >= total - 8)  b = 8'(bl >> (8 * (total - 1 - i)));
      else                      b = 8'h00;
      w = {w[23:0], b};
      if (i % 4 == 3) push_word(w, i == total - 1);
    end
  endtask

  // Issue a message; bytes_ovr >= 0 replaces the last-word byte count,
  // max_words > 0 stops early without a last word.
  task automatic send_msg(input int nbytes, input int bytes_ovr, input bit hold_start,
                          input int max_words);
    int nw;
    int cnt;
    logic [31:0] w;
    nw  = (nbytes == 0) ? 1 : (nbytes + 3) / 4;
    if (max_words > 0 && max_words < nw) nw = max_words;
    cnt = 0;
    while ((pif.busy_o || pif.done_o) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("idle_before_start", 64'(cnt < 200), 64'd1);
    @(posedge clk);
    #1;
    pif.msg_start_i = 1'b1;
    @(posedge clk);
    #1;
    pif.msg_start_i = hold_start;
    for (int wi = 0; wi < nw; wi++) begin
      for (int j = 0; j < 4; j++) begin
        int k;
        k = 4 * wi + j;
        w = {w[23:0], (k < nbytes) ? msg_buf[k] : 8'hEE};
      end
      pif.msg_dat_i  = w;
      pif.msg_last_i = (max_words == 0) && (wi == nw - 1);
      pif.msg_bytes_i = 3'd0;
      if (pif.msg_last_i)
        pif.msg_bytes_i = (bytes_ovr >= 0) ? 3'(bytes_ovr) : 3'(nbytes - 4 * wi);
      pif.msg_vld_i = 1'b1;
      cnt = 0;
      @(negedge clk);
      while (!pif.msg_rdy_o && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      if (cnt >= 100) begin
        errors++;
        $display("FAIL msg_rdy_timeout: msg_rdy_o=0 required 1 within 100 cycles");
      end
      @(posedge clk);
      #1;
    end
    pif.msg_vld_i   = 1'b0;
    pif.msg_last_i  = 1'b0;
    pif.msg_start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cnt;
    cnt = 0;
    while ((sb.size() != 0 || done_cnt != exp_done) && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    chk({name, "_pending_words"}, 64'(sb.size()), 64'd0);
    chk({name, "_done_count"}, 64'(done_cnt), 64'(exp_done));
  endtask

  task automatic load_abc();
    msg_buf[0] = 8'h61;
    msg_buf[1] = 8'h62;
    msg_buf[2] = 8'h63;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    word_no  = 0;
    done_cnt = 0;
    exp_done = 0;
    stall_en = 1'b0;
    rst      = 1'b1;
    pif.msg_start_i = 1'b0;
    pif.msg_vld_i   = 1'b0;
    pif.msg_dat_i   = '0;
    pif.msg_last_i  = 1'b0;
    pif.msg_bytes_i = '0;
    for (int i = 0; i < 64; i++) msg_buf[i] = 8'(i + 1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_msg_rdy", 64'(pif.msg_rdy_o), 64'd0);
    chk("rst_wr_en", 64'(pif.fifo_wr_en_o), 64'd0);
    chk("rst_wr_dat", 64'(pif.fifo_wr_dat_o), 64'd0);
    chk("rst_busy", 64'(pif.busy_o), 64'd0);
    chk("rst_done", 64'(pif.done_o), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_msg_rdy", 64'(pif.msg_rdy_o), 64'd0);

    // "abc": 61626380, 14 zeros, 00000018
    load_abc();
    push_word(32'h61626380, 1'b0);
    for (int i = 0; i < 14; i++) push_word(32'h0, 1'b0);
    push_word(32'h00000018, 1'b1);
    exp_done++;
    send_msg(3, -1, 1'b0, 0);
    wait_done("abc");

    // Empty message: 80000000, 15 zeros
    push_word(32'h80000000, 1'b0);
    for (int i = 0; i < 14; i++) push_word(32'h0, 1'b0);
    push_word(32'h00000000, 1'b1);
    exp_done++;
    send_msg(0, -1, 1'b0, 0);
    wait_done("empty");

    // 55 bytes: marker merged into word 13, length 0x1B8
    for (int i = 0; i < 64; i++) msg_buf[i] = 8'(i + 1);
    push_model(55);
    exp_done++;
    send_msg(55, -1, 1'b0, 0);
    wait_done("b55");

    // 56 bytes: marker word at index 14, second block, length 0x1C0
    push_model(56);
    exp_done++;
    send_msg(56, -1, 1'b0, 0);
    wait_done("b56");

    // "abc" under random backpressure
    load_abc();
    push_word(32'h61626380, 1'b0);
    for (int i = 0; i < 14; i++) push_word(32'h0, 1'b0);
    push_word(32'h00000018, 1'b1);
    exp_done++;
    stall_en = 1'b1;
    send_msg(3, -1, 1'b0, 0);
    wait_done("abc_stall");

    // 56 bytes under backpressure, msg_start_i held high (ignored mid-message)
    for (int i = 0; i < 64; i++) msg_buf[i] = 8'(i + 1);
    push_model(56);
    exp_done++;
    send_msg(56, -1, 1'b1, 0);
    wait_done("b56_stall");
    stall_en = 1'b0;
    repeat (2) @(posedge clk);

    // Byte count above 4 on the last word behaves as 4
    load_abc();
    msg_buf[3] = 8'h64;
    push_model(4);
    exp_done++;
    send_msg(4, 7, 1'b0, 0);
    wait_done("nbytes_gt4");

    // Asynchronous reset in the middle of DATA
    for (int i = 0; i < 64; i++) msg_buf[i] = 8'(i + 1);
    push_model(56);
    send_msg(56, -1, 1'b0, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_wr_en", 64'(pif.fifo_wr_en_o), 64'd0);
    chk("async_rst_wr_dat", 64'(pif.fifo_wr_dat_o), 64'd0);
    chk("async_rst_busy", 64'(pif.busy_o), 64'd0);
    chk("async_rst_msg_rdy", 64'(pif.msg_rdy_o), 64'd0);
    sb.delete();
    word_no = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Clean "abc" after the reset
    load_abc();
    push_word(32'h61626380, 1'b0);
    for (int i = 0; i < 14; i++) push_word(32'h0, 1'b0);
    push_word(32'h00000018, 1'b1);
    exp_done++;
    send_msg(3, -1, 1'b0, 0);
    wait_done("abc_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Message-side front end for the SHA-256 hashing engine. It accepts a raw message as big-endian 32-bit words with a byte count on the last word. It applies FIPS 180-4 padding: a 0x80 marker, zero fill, and the 64-bit bit length. It writes the resulting whole 512-bit blocks, as 16 words each, into the engine's input FIFO. It is the writer for the FIFO the engine reads, so the engine always finds complete, correctly padded blocks.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `msg_start_i`  in  1  pulse; begins a new message; honoured only in IDLE
- `msg_vld_i`  in  1  message word valid
- `msg_rdy_o`  out  1  padder can accept a message word
- `msg_dat_i`  in  32  message word; byte 0 in [31:24]
- `msg_last_i`  in  1  current word is the final message word
- `msg_bytes_i`  in  3  valid bytes in the last word, 0..4; ignored unless `msg_last_i`
- `fifo_wr_en_o`  out  1  FIFO write strobe
- `fifo_wr_dat_o`  out  32  FIFO write data
- `fifo_full_i`  in  1  FIFO full
- `busy_o`  out  1  message in progress (state != IDLE)
- `done_o`  out  1  one-cycle pulse when the final length word is written

## Operation
- States: IDLE, DATA, PAD, ZERO, LEN_HI, LEN_LO.
- IDLE:
  - `msg_start_i` clears the bit counter and the word index, then goes to DATA.
  - `msg_start_i` in any other state is ignored.
- DATA:
  - Word accepted when `msg_vld_i` and `msg_rdy_o` are both high.
  - Non-last word: emitted unchanged; bit counter += 32.
- Last word in DATA, with n = `msg_bytes_i`:
  - n=0..3: emit (data masked to n bytes) | (0x80 << (24-8n)); bit counter += 8n; go to ZERO.
  - n=4: emit the word unchanged; bit counter += 32; go to PAD. PAD emits 0x80000000, then goes to ZERO.
  - n>4: treated as 4.
  - An empty message is a single last word with n=0, giving pad word 0x80000000.
- Word index:
  - 4-bit, counts every word written, wraps 15→0.
- ZERO:
  - Emits 0x00000000 until the word index equals 14, then goes to LEN_HI.
  - If the marker word landed at index 14 or 15, ZERO runs through the wrap and fills a full extra block up to index 14.
- Length words:
  - LEN_HI emits bitcnt[63:32]; LEN_LO emits bitcnt[31:0].
  - After LEN_LO is written, `done_o` pulses and the state returns to IDLE.
- Bit counter:
  - 64-bit, wraps modulo 2^64.
- Output stage:
  - One-entry register (`out_vld`, `out_dat`).
  - `fifo_wr_en_o` = `out_vld` & ~`fifo_full_i` (combinational).
  - `fifo_wr_dat_o` = `out_dat`.
  - The stage loads when it is empty or being drained in the same cycle.
- `msg_rdy_o` = (state==DATA) & output stage loadable.

## Timing
- Reset values: `msg_rdy_o`=0, `fifo_wr_en_o`=0, `fifo_wr_dat_o`=0, `busy_o`=0, `done_o`=0, state IDLE, counters 0.
- Throughput: one word per cycle while `fifo_full_i`=0.
- Latency: a word accepted at edge t is presented on `fifo_wr_dat_o` from cycle t+1.
- `msg_start_i` at edge t: `busy_o`=1 and `msg_rdy_o`=1 from cycle t+1, provided the output stage is empty.
- Backpressure:
  - While `fifo_full_i`=1, `fifo_wr_en_o`=0 and `out_dat` holds.
  - No word is lost or duplicated.
- `done_o`: asserted in the cycle after the edge at which LEN_LO is written.
- Simultaneous events:
  - Drain and load in the same cycle are allowed with no bubble.
  - `msg_start_i` coinciding with `done_o` is ignored; the state is IDLE only from the following cycle.
- Reset mid-message:
  - All state clears immediately and asynchronously.
  - Partially written blocks stay in the FIFO; the system must flush the FIFO and the engine.

## Structure
- Shared package `sha256_pkg` holds:
  - the padder state enum;
  - `SHA256_PAD_MARKER` = 32'h80000000;
  - `SHA256_WORDS_PER_BLK` = 16;
  - `SHA256_LEN_IDX` = 14.
- The initial-hash and K constants move into the same package so the engine shares them.
- One sub-module, `sha256_out_stage`: the one-entry registered FIFO write stage with the full/drain logic.

## Test plan
- "abc": one word 0x61626300, n=3, last → 16 words: 0x61626380, 13×0, 0x00000000, 0x00000018, then `done_o`. Downstream engine hash = ba7816bf…f20015ad.
- Empty message: n=0 → 0x80000000, 13×0, 0x00000000, 0x00000000.
- 55 bytes: 13 full words plus a last word with n=3 at index 13 → marker merged in word 13, word14=0, word15=0x000001B8; 16 words total.
- 56 bytes: 14 words, last n=4 → 14 data words, 0x80000000 at index 14, 0 at index 15, then 14×0, 0x00000000, 0x000001C0; 32 words total.
- Random `fifo_full_i` toggling during the "abc" and 56-byte cases → same word sequence; no write while full; data stable during stalls.
- Assert `rst` mid-DATA → outputs go to 0 without waiting for a clock edge; a new `msg_start_i` then produces a correct "abc" result.
